// File: rtl/output_deskew.sv
// output_deskew: reassembles the skewed column outputs of a 2x2 systolic
// array into a full 2x2 result matrix, held until the consumer acknowledges.
module output_deskew #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] c_in1,
  input  logic [DATA_W-1:0] c_in2,
  input  logic              result_ack,
  output logic [DATA_W-1:0] c11,
  output logic [DATA_W-1:0] c12,
  output logic [DATA_W-1:0] c21,
  output logic [DATA_W-1:0] c22,
  output logic              result_valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0] state;
  logic [1:0] k;

  // Burst sequencing, lane capture, result handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      c11          <= '0;
      c12          <= '0;
      c21          <= '0;
      c22          <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            c11   <= c_in1;
            k     <= 2'd1;
            state <= COLLECT;
          end
        end

        COLLECT: begin
          // A new start cannot be honoured mid-burst; flag it and carry on.
          if (start) overrun <= 1'b1;
          if (k == 2'd1) begin
            c21 <= c_in1;
            c12 <= c_in2;
            k   <= 2'd2;
          end else if (k == 2'd2) begin
            c22          <= c_in2;
            k            <= '0;
            state        <= HOLD;
            result_valid <= 1'b1;
          end else begin
            // k cannot legally be 0 here; recover to a clean idle.
            k     <= '0;
            state <= IDLE;
          end
        end

        HOLD: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            if (start) begin
              // Back-to-back burst: c11 of the next burst arrives with the ack.
              c11   <= c_in1;
              k     <= 2'd1;
              state <= COLLECT;
            end else begin
              state <= IDLE;
            end
          end else if (start) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          k            <= '0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  // Busy reflects the collection phase only.
  always_comb begin
    busy = (state == COLLECT);
  end

endmodule
